// File: rtl/video_dither.sv
// Three-stage RGB -> luma -> binary pixel pipeline with fixed-threshold or 4x4 Bayer dithering.
// de/sync/coordinates travel alongside the pixel so every output is aligned with bin_data.
module video_dither #(
   parameter bit INVERT   = 1'b0,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [23:0] rgb_data,
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        mode,
   input  logic [7:0]  thresh,
   output logic        bin_data,
   output logic        de_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic [9:0]  x_pos,
   output logic [8:0]  y_pos,
   output logic        frame_start
);
   localparam bit SYNC_IDLE = ~SYNC_POL;

   logic       de_prev_q, de_prev_d, vs_prev_q, vs_prev_d, armed_q, armed_d, mode_q, mode_d;
   logic [9:0] col_q, col_d;
   logic [8:0] row_q, row_d;
   logic [7:0] thr_q, thr_d;

   logic [15:0] s1_pr_q, s1_pr_d, s1_pg_q, s1_pg_d, s1_pb_q, s1_pb_d;
   logic        s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_fs_q, s1_fs_d;
   logic        s1_mode_q, s1_mode_d;
   logic [9:0]  s1_x_q, s1_x_d;
   logic [8:0]  s1_y_q, s1_y_d;
   logic [7:0]  s1_thr_q, s1_thr_d;

   logic [7:0]  s2_luma_q, s2_luma_d, s2_thr_q, s2_thr_d;
   logic        s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_fs_q, s2_fs_d;
   logic        s2_mode_q, s2_mode_d;
   logic [9:0]  s2_x_q, s2_x_d;
   logic [8:0]  s2_y_q, s2_y_d;

   logic        bin_q, bin_d, de_o_q, de_o_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d, fs_o_q, fs_o_d;
   logic [9:0]  x_o_q, x_o_d;
   logic [8:0]  y_o_q, y_o_d;

   logic        vs_edge, de_fall, fs_now;
   logic [3:0]  bay_m;
   logic [7:0]  thr_eff;

   function automatic logic [3:0] bayer(input logic [1:0] yy, input logic [1:0] xx);
      logic [3:0] m;
      case ({yy, xx})
         4'h0: m = 4'd0;   4'h1: m = 4'd8;   4'h2: m = 4'd2;   4'h3: m = 4'd10;
         4'h4: m = 4'd12;  4'h5: m = 4'd4;   4'h6: m = 4'd14;  4'h7: m = 4'd6;
         4'h8: m = 4'd3;   4'h9: m = 4'd11;  4'hA: m = 4'd1;   4'hB: m = 4'd9;
         4'hC: m = 4'd15;  4'hD: m = 4'd7;   4'hE: m = 4'd13;  default: m = 4'd5;
      endcase
      return m;
   endfunction

   always_comb begin
      vs_edge   = (vsync == SYNC_POL) && (vs_prev_q != SYNC_POL);
      de_fall   = !de && de_prev_q;
      // A vsync edge coinciding with de starts the frame on that very pixel.
      fs_now    = de && (armed_q || vs_edge);
      de_prev_d = de;
      vs_prev_d = vsync;

      col_d = col_q;
      if (de) begin
         if (col_q != 10'd1023) col_d = col_q + 10'd1;
      end else if (de_fall) begin
         col_d = '0;
      end

      row_d = row_q;
      if (vs_edge)                            row_d = '0;
      else if (de_fall && row_q != 9'd511)    row_d = row_q + 9'd1;

      armed_d = armed_q;
      if (fs_now)       armed_d = 1'b0;
      else if (vs_edge) armed_d = 1'b1;

      thr_d  = fs_now ? thresh : thr_q;
      mode_d = fs_now ? mode   : mode_q;

      s1_pr_d   = 16'(rgb_data[23:16]) * 16'd77;
      s1_pg_d   = 16'(rgb_data[15:8])  * 16'd150;
      s1_pb_d   = 16'(rgb_data[7:0])   * 16'd29;
      s1_de_d   = de;
      s1_hs_d   = hsync;
      s1_vs_d   = vsync;
      s1_x_d    = col_q;
      s1_y_d    = vs_edge ? '0 : row_q;
      s1_fs_d   = fs_now;
      s1_thr_d  = thr_d;
      s1_mode_d = mode_d;

      s2_luma_d = 8'((s1_pr_q + s1_pg_q + s1_pb_q) >> 8);
      s2_de_d   = s1_de_q;
      s2_hs_d   = s1_hs_q;
      s2_vs_d   = s1_vs_q;
      s2_x_d    = s1_x_q;
      s2_y_d    = s1_y_q;
      s2_fs_d   = s1_fs_q;
      s2_thr_d  = s1_thr_q;
      s2_mode_d = s1_mode_q;

      bay_m   = bayer(s2_y_q[1:0], s2_x_q[1:0]);
      thr_eff = s2_mode_q ? {bay_m, 4'h8} : s2_thr_q;
      bin_d   = s2_de_q && ((s2_luma_q > thr_eff) ^ INVERT);
      de_o_d  = s2_de_q;
      hs_o_d  = s2_hs_q;
      vs_o_d  = s2_vs_q;
      x_o_d   = s2_x_q;
      y_o_d   = s2_y_q;
      fs_o_d  = s2_fs_q;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         de_prev_q <= 1'b0;      vs_prev_q <= SYNC_IDLE;  armed_q <= 1'b0;
         col_q     <= '0;        row_q     <= '0;
         thr_q     <= 8'd128;    mode_q    <= 1'b0;
         s1_pr_q   <= '0;        s1_pg_q   <= '0;         s1_pb_q  <= '0;
         s1_de_q   <= 1'b0;      s1_hs_q   <= SYNC_IDLE;  s1_vs_q  <= SYNC_IDLE;
         s1_x_q    <= '0;        s1_y_q    <= '0;         s1_fs_q  <= 1'b0;
         s1_thr_q  <= '0;        s1_mode_q <= 1'b0;
         s2_luma_q <= '0;        s2_de_q   <= 1'b0;
         s2_hs_q   <= SYNC_IDLE; s2_vs_q   <= SYNC_IDLE;
         s2_x_q    <= '0;        s2_y_q    <= '0;         s2_fs_q  <= 1'b0;
         s2_thr_q  <= '0;        s2_mode_q <= 1'b0;
         bin_q     <= 1'b0;      de_o_q    <= 1'b0;
         hs_o_q    <= SYNC_IDLE; vs_o_q    <= SYNC_IDLE;
         x_o_q     <= '0;        y_o_q     <= '0;         fs_o_q   <= 1'b0;
      end else begin
         de_prev_q <= de_prev_d; vs_prev_q <= vs_prev_d;  armed_q  <= armed_d;
         col_q     <= col_d;     row_q     <= row_d;
         thr_q     <= thr_d;     mode_q    <= mode_d;
         s1_pr_q   <= s1_pr_d;   s1_pg_q   <= s1_pg_d;    s1_pb_q  <= s1_pb_d;
         s1_de_q   <= s1_de_d;   s1_hs_q   <= s1_hs_d;    s1_vs_q  <= s1_vs_d;
         s1_x_q    <= s1_x_d;    s1_y_q    <= s1_y_d;     s1_fs_q  <= s1_fs_d;
         s1_thr_q  <= s1_thr_d;  s1_mode_q <= s1_mode_d;
         s2_luma_q <= s2_luma_d; s2_de_q   <= s2_de_d;
         s2_hs_q   <= s2_hs_d;   s2_vs_q   <= s2_vs_d;
         s2_x_q    <= s2_x_d;    s2_y_q    <= s2_y_d;     s2_fs_q  <= s2_fs_d;
         s2_thr_q  <= s2_thr_d;  s2_mode_q <= s2_mode_d;
         bin_q     <= bin_d;     de_o_q    <= de_o_d;
         hs_o_q    <= hs_o_d;    vs_o_q    <= vs_o_d;
         x_o_q     <= x_o_d;     y_o_q     <= y_o_d;      fs_o_q   <= fs_o_d;
      end
   end

   assign bin_data    = bin_q;
   assign de_o        = de_o_q;
   assign hsync_o     = hs_o_q;
   assign vsync_o     = vs_o_q;
   assign x_pos       = x_o_q;
   assign y_pos       = y_o_q;
   assign frame_start = fs_o_q;

endmodule

// File: tb/tb_video_dither.sv
// Bench for video_dither: two instances (INVERT=0/1) driven identically, checked every cycle
// against a pixel-level reference model plus literal checks of key scenarios.
module tb_video_dither;
   localparam bit SYNC_POL = 1'b1;

   logic        pclk = 1'b0, rst = 1'b1;
   logic [23:0] rgb_data = '0;
   logic        de = 1'b0, hsync = ~SYNC_POL, vsync = ~SYNC_POL, mode = 1'b0;
   logic [7:0]  thresh = 8'd128;

   logic       bin0, de_o0, hs_o0, vs_o0, fs0, bin1, de_o1, hs_o1, vs_o1, fs1;
   logic [9:0] x0, x1;
   logic [8:0] y0, y1;

   video_dither #(.INVERT(1'b0), .SYNC_POL(SYNC_POL)) dut0 (
      .pclk(pclk), .rst(rst), .rgb_data(rgb_data), .de(de), .hsync(hsync), .vsync(vsync),
      .mode(mode), .thresh(thresh), .bin_data(bin0), .de_o(de_o0), .hsync_o(hs_o0),
      .vsync_o(vs_o0), .x_pos(x0), .y_pos(y0), .frame_start(fs0));

   video_dither #(.INVERT(1'b1), .SYNC_POL(SYNC_POL)) dut1 (
      .pclk(pclk), .rst(rst), .rgb_data(rgb_data), .de(de), .hsync(hsync), .vsync(vsync),
      .mode(mode), .thresh(thresh), .bin_data(bin1), .de_o(de_o1), .hsync_o(hs_o1),
      .vsync_o(vs_o1), .x_pos(x1), .y_pos(y1), .frame_start(fs1));

   always #5 pclk = ~pclk;

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit rst; bit de; bit hs; bit vs; int x; int y; bit fs; bit bin;
   } exp_t;

   int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

   function automatic int luma(input logic [23:0] c);
      return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
   endfunction

   function automatic bit decide(input int yv, input int x, input int y, input bit md, input int thr);
      int t;
      t = md ? 16 * bay[y % 4][x % 4] + 8 : thr;
      return yv > t;
   endfunction

   function automatic int cap(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   exp_t p0, p1, p2, e, r;
   int   m_pix, m_lines, m_thr;
   bit   m_de_prev, m_vs_prev, m_armed, m_mode, vedge, run_chk = 1'b0;

   always @(posedge pclk) begin
      if (rst) begin
         r = '{rst: 1'b1, de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, x: 0, y: 0, fs: 1'b0, bin: 1'b0};
         p0 = r; p1 = r; p2 = r;
         m_pix = 0; m_lines = 0; m_thr = 128; m_mode = 1'b0;
         m_de_prev = 1'b0; m_vs_prev = 1'b0; m_armed = 1'b0;
      end else begin
         vedge = (vsync == SYNC_POL) && !m_vs_prev;
         if (vedge) begin m_lines = 0; m_armed = 1'b1; end
         r = '{rst: 1'b0, de: de, hs: hsync, vs: vsync, x: 0, y: 0, fs: 1'b0, bin: 1'b0};
         if (de) begin
            r.x  = cap(m_pix, 1023);
            r.y  = cap(m_lines, 511);
            r.fs = m_armed;
            if (m_armed) begin m_thr = int'(thresh); m_mode = mode; m_armed = 1'b0; end
            r.bin = decide(luma(rgb_data), r.x, r.y, m_mode, m_thr);
            m_pix++;
         end else if (m_de_prev) begin
            m_pix = 0;
            if (!vedge) m_lines++;
         end
         m_de_prev = de;
         m_vs_prev = (vsync == SYNC_POL);
         p2 = p1; p1 = p0; p0 = r;
      end
      e = p2;
      run_chk = 1'b1;
   end

   // ---------------- compare process ----------------
   int fs_cnt = 0, fs_x = -1, fs_y = -1, last_x = -1, last_y = -1, first_one = -1, blk_ones = 0;
   int first_x = -1, first_y = -1;
   bit got_first = 1'b0;

   always @(negedge pclk) if (run_chk) begin
      chk("de_o", de_o0, e.de);
      chk("hsync_o", hs_o0, e.hs);
      chk("vsync_o", vs_o0, e.vs);
      chk("de_o_inv", de_o1, e.de);
      chk("hsync_o_inv", hs_o1, e.hs);
      chk("vsync_o_inv", vs_o1, e.vs);
      if (e.de || e.rst) begin
         chk("x_pos", x0, e.x);
         chk("y_pos", y0, e.y);
         chk("x_pos_inv", x1, e.x);
         chk("y_pos_inv", y1, e.y);
      end
      chk("frame_start", fs0, e.fs);
      chk("frame_start_inv", fs1, e.fs);
      chk("bin_data", bin0, e.bin);
      chk("bin_data_inv", bin1, e.de ? !e.bin : 1'b0);
      if (de_o0) begin
         last_x = x0; last_y = y0;
         if (!got_first) begin got_first = 1'b1; first_x = x0; first_y = y0; end
         if (fs0) begin fs_cnt++; fs_x = x0; fs_y = y0; end
         if (bin0) begin
            blk_ones++;
            if (first_one < 0) first_one = x0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      de = 1'b0;
      repeat (n) tick();
   endtask

   function automatic logic [23:0] pix(input int kind, input int i);
      logic [7:0] v;
      v = 8'(i);
      case (kind)
         1:       return {v, v, v};
         2:       return 24'h808080;
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic line(input int n, input int kind, input int hblank);
      for (int i = 0; i < n; i++) begin
         de = 1'b1;
         rgb_data = pix(kind, i);
         tick();
      end
      de = 1'b0;
      rgb_data = 24'($urandom);
      hsync = SYNC_POL;
      tick();
      hsync = ~SYNC_POL;
      idle(hblank);
   endtask

   task automatic vsync_pulse();
      de = 1'b0;
      vsync = SYNC_POL;
      repeat (2) tick();
      vsync = ~SYNC_POL;
      idle(2);
   endtask

   task automatic single_pixel(input logic [23:0] c, input bit exp_bin);
      de = 1'b1;
      rgb_data = c;
      tick();
      de = 1'b0;
      tick();
      tick();
      chk("sp_de_o", de_o0, 1);
      chk("sp_bin", bin0, exp_bin);
      chk("sp_bin_inv", bin1, !exp_bin);
      tick();
      chk("sp_de_o_after", de_o0, 0);
      idle(2);
   endtask

   task automatic clear_caps();
      fs_cnt = 0; fs_x = -1; fs_y = -1; first_one = -1; blk_ones = 0; got_first = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   int cnt;

   initial begin
      chk("model_luma_white", luma(24'hFFFFFF), 255);
      chk("model_luma_black", luma(24'h000000), 0);
      cnt = -1;
      for (int v = 255; v >= 0; v--) if (decide(v, 0, 0, 1'b0, 100)) cnt = v;
      chk("model_ramp_flip", cnt, 101);
      cnt = 0;
      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 4; xx++) cnt += int'(decide(128, xx, yy, 1'b1, 0));
      chk("model_bayer_ones", cnt, 8);

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         de = 1'(i); rgb_data = 24'($urandom); hsync = SYNC_POL; tick();
      end
      chk("reset_de_o", de_o0, 0);
      chk("reset_hsync_o", hs_o0, 0);
      rst = 1'b0; hsync = ~SYNC_POL;
      idle(3);

      single_pixel(24'hFFFFFF, 1'b1);
      single_pixel(24'h000000, 1'b0);

      // Threshold 100 ramp; a mid-frame change to 0/Bayer must not apply yet.
      thresh = 8'd100; mode = 1'b0;
      clear_caps();
      vsync_pulse();
      line(256, 1, 4);
      chk("ramp_first_one", first_one, 101);
      chk("ramp_fs_count", fs_cnt, 1);
      chk("ramp_fs_x", fs_x, 0);
      chk("ramp_fs_y", fs_y, 0);
      thresh = 8'd0; mode = 1'b1;
      first_one = -1;
      line(256, 1, 4);
      chk("ramp_midframe_first_one", first_one, 101);

      // Bayer on flat grey 128.
      vsync_pulse();
      clear_caps();
      for (int l = 0; l < 4; l++) line(4, 2, 2);
      chk("bayer_block_ones", blk_ones, 8);

      // vsync edge and de in the same cycle.
      clear_caps();
      de = 1'b1; vsync = SYNC_POL; rgb_data = 24'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin rgb_data = 24'($urandom); tick(); end
      vsync = ~SYNC_POL;
      line(2, 0, 3);
      chk("vs_de_fs_count", fs_cnt, 1);
      chk("vs_de_fs_x", fs_x, 0);
      chk("vs_de_fs_y", fs_y, 0);

      // Random frames with random threshold/mode, changed mid-frame too.
      for (int f = 0; f < 6; f++) begin
         thresh = 8'($urandom); mode = 1'($urandom_range(0, 1));
         vsync_pulse();
         for (int l = 0; l < $urandom_range(3, 8); l++) begin
            line($urandom_range(1, 40), 0, $urandom_range(1, 5));
            if (l == 1) begin thresh = 8'($urandom); mode = 1'($urandom_range(0, 1)); end
         end
      end

      // 480-line frame, last line 640 wide.
      thresh = 8'($urandom); mode = 1'b0;
      clear_caps();
      vsync_pulse();
      for (int l = 0; l < 479; l++) line(2, 0, 1);
      line(640, 0, 3);
      chk("frame_fs_count", fs_cnt, 1);
      chk("frame_fs_x", fs_x, 0);
      chk("frame_fs_y", fs_y, 0);
      chk("frame_last_x", last_x, 639);
      chk("frame_last_y", last_y, 479);

      // Column and row saturation.
      line(1100, 0, 3);
      chk("col_saturate", last_x, 1023);
      for (int l = 0; l < 40; l++) line(1, 0, 1);
      chk("row_saturate", last_y, 511);

      // One-cycle reset mid-line with vsync held active through release.
      for (int i = 0; i < 5; i++) begin de = 1'b1; rgb_data = 24'($urandom); tick(); end
      rst = 1'b1; hsync = SYNC_POL; vsync = SYNC_POL;
      tick();
      chk("midrst_de_o", de_o0, 0);
      chk("midrst_hsync_o", hs_o0, 0);
      chk("midrst_x_pos", x0, 0);
      rst = 1'b0; hsync = ~SYNC_POL;
      clear_caps();
      for (int i = 0; i < 6; i++) begin
         rgb_data = 24'($urandom);
         tick();
         if (i == 1) vsync = ~SYNC_POL;
      end
      idle(5);
      chk("midrst_first_x", first_x, 0);
      chk("midrst_first_y", first_y, 0);
      chk("midrst_fs_count", fs_cnt, 1);

      line(10, 0, 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected sequence end");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
